// File: rtl/axi_pkg.sv
// Shared definitions for the sram-like to AXI3 bridges: FSM states,
// constant AXI encodings and the byte-strobe decode.
package axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Size 3 has no sram-like meaning and falls through to a full word.
    function automatic logic [3:0] wstrb_from_size(input logic [1:0] size,
                                                   input logic [1:0] offset);
        logic [3:0] strb;
        case (size)
            SIZE_BYTE: strb = 4'b0001 << offset;
            SIZE_HALF: strb = offset[1] ? 4'b1100 : 4'b0011;
            default:   strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/sram_axi_wstrb.sv
// Combinational size/offset to AXI write-strobe decoder, shared by the
// instruction- and data-side bridges.
module sram_axi_wstrb
    import axi_pkg::*;
(
    input  logic [1:0] size_i,
    input  logic [1:0] offset_i,
    output logic [3:0] wstrb_o
);

    assign wstrb_o = wstrb_from_size(size_i, offset_i);

endmodule

// File: rtl/cache_axi_bridge.sv
// Data-cache memory-side responder: turns each accepted sram-like request
// into one single-beat AXI3 read or write, one transaction in flight.
module cache_axi_bridge
    import axi_pkg::*;
#(
    parameter int unsigned         ID_WIDTH = 4,
    parameter logic [ID_WIDTH-1:0] AXI_ID   = ID_WIDTH'(1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [31:0]         data_addr,
    input  logic [31:0]         data_wdata,
    output logic [31:0]         data_rdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [ID_WIDTH-1:0] arid,
    output logic [31:0]         araddr,
    output logic [3:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [1:0]          arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,
    input  logic [ID_WIDTH-1:0] rid,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    output logic [ID_WIDTH-1:0] awid,
    output logic [31:0]         awaddr,
    output logic [3:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [1:0]          awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,
    output logic [ID_WIDTH-1:0] wid,
    output logic [31:0]         wdata,
    output logic [3:0]          wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [ID_WIDTH-1:0] bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [3:0]  req_wstrb;
    logic        aw_fin, w_fin;

    // Response IDs, status and last flags carry no information for single beats.
    logic unused_inputs;
    assign unused_inputs = ^{rid, rresp, rlast, bid, bresp};

    sram_axi_wstrb u_wstrb (
        .size_i   (data_size),
        .offset_i (data_addr[1:0]),
        .wstrb_o  (req_wstrb)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        aw_fin       = 1'b0;
        w_fin        = 1'b0;
        arvalid      = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        rready       = 1'b0;
        bready       = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        case (state_q)
            S_IDLE: begin
                data_addr_ok = data_req;
                if (data_req) begin
                    addr_d  = data_addr;
                    size_d  = data_size;
                    wdata_d = data_wdata;
                    wstrb_d = req_wstrb;
                    state_d = data_wr ? S_WR_REQ : S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    data_data_ok = 1'b1;
                    data_rdata   = rdata;
                    state_d      = S_IDLE;
                end
            end
            S_WR_REQ: begin
                // AW and W complete independently; leave once both have.
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                aw_fin  = aw_done_q || awready;
                w_fin   = w_done_q || wready;
                if (aw_fin && w_fin) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WR_RESP;
                end else begin
                    aw_done_d = aw_fin;
                    w_done_d  = w_fin;
                end
            end
            S_WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    data_data_ok = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Nothing is accepted, completed or offered on the bus while in reset.
        if (rst) begin
            arvalid      = 1'b0;
            awvalid      = 1'b0;
            wvalid       = 1'b0;
            rready       = 1'b0;
            bready       = 1'b0;
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            data_rdata   = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= 32'h0;
            size_q    <= 2'd0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arlen   = 4'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awlen   = 4'd0;
    assign awsize  = {1'b0, size_q};
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;

    assign wid     = AXI_ID;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: reset, read/write handshake orders,
// refusal while busy, mid-transaction reset and a small memory-model mix.
module tb_cache_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [3:0]  arlen, arcache, awlen, awcache, wstrb;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem  [0:3];
    logic [31:0] gold [0:3];

    always #5 clk = ~clk;

    cache_axi_bridge dut (
        .clk(clk), .rst(rst),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_strb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0: begin
                case (off)
                    2'd0: return 4'b0001;
                    2'd1: return 4'b0010;
                    2'd2: return 4'b0100;
                    default: return 4'b1000;
                endcase
            end
            2'd1: return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic half_write(input int aw_dly, input int w_dly, input string tag);
        int n_aw, n_w, n_ok, last;
        n_aw = 0; n_w = 0; n_ok = 0;
        last = (aw_dly > w_dly) ? aw_dly : w_dly;
        data_req = 1; data_wr = 1; data_size = 2'd1;
        data_addr = 32'h8000_0002; data_wdata = 32'h5A5A_0000;
        #1; check({tag, "_addr_ok"}, data_addr_ok, 1);
        next_cycle();
        data_req = 0;
        for (int k = 0; k <= last; k++) begin
            awready = (k >= aw_dly);
            wready  = (k >= w_dly);
            #1;
            if (awvalid && awready) begin
                n_aw++;
                check({tag, "_awaddr"}, awaddr, 32'h8000_0002);
            end
            if (wvalid && wready) begin
                n_w++;
                check({tag, "_wstrb"}, wstrb, 4'b1100);
                check({tag, "_wdata"}, wdata, 32'h5A5A_0000);
            end
            if (data_data_ok) n_ok++;
            next_cycle();
        end
        awready = 0; wready = 0; bvalid = 1;
        #1;
        check({tag, "_bready"}, bready, 1);
        check({tag, "_valids_low"}, {awvalid, wvalid}, 0);
        if (data_data_ok) n_ok++;
        next_cycle();
        bvalid = 0;
        #1;
        check({tag, "_idle_no_ok"}, {data_data_ok, bready}, 0);
        check({tag, "_aw_hs"}, n_aw, 1);
        check({tag, "_w_hs"}, n_w, 1);
        check({tag, "_data_ok"}, n_ok, 1);
    endtask

    // Drives one request and answers it as an AXI memory with random stalls.
    task automatic axi_txn(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd);
        int n_ok, d_a, d_w, t_r, t_b;
        logic ar_seen, aw_seen, w_seen, done;
        logic [31:0] cap_addr, cap_data;
        logic [3:0] cap_strb;
        n_ok = 0; done = 0; ar_seen = 0; aw_seen = 0; w_seen = 0;
        t_r = 0; t_b = 0; rd = 0; cap_addr = 0; cap_data = 0; cap_strb = 0;
        d_a = int'($urandom_range(0, 3));
        d_w = int'($urandom_range(0, 3));
        data_req = 1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
        #1; check("mix_addr_ok", data_addr_ok, 1);
        next_cycle();
        data_req = 0;
        for (int g = 0; g < 40 && !done; g++) begin
            arready = (g >= d_a);
            awready = (g >= d_a);
            wready  = (g >= d_w);
            rvalid  = ar_seen && (g >= t_r);
            rdata   = rvalid ? mem[cap_addr[3:2]] : 32'h0;
            bvalid  = aw_seen && w_seen && (g >= t_b);
            #1;
            if (arvalid && arready) begin
                ar_seen = 1; cap_addr = araddr; t_r = g + 1 + int'($urandom_range(0, 2));
            end
            if (awvalid && awready) begin
                aw_seen = 1; cap_addr = awaddr;
            end
            if (wvalid && wready) begin
                w_seen = 1; cap_data = wdata; cap_strb = wstrb;
            end
            if (aw_seen && w_seen && t_b == 0) t_b = g + 1 + int'($urandom_range(0, 2));
            if (bvalid && bready) begin
                for (int b = 0; b < 4; b++)
                    if (cap_strb[b]) mem[cap_addr[3:2]][8*b +: 8] = cap_data[8*b +: 8];
            end
            if (data_data_ok) begin
                n_ok++; rd = data_rdata; done = 1;
            end
            next_cycle();
        end
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0; rdata = 0;
        check("mix_one_data_ok", n_ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        m_wr;
        logic [1:0]  m_sz, m_off, m_idx;
        logic [31:0] m_wd, m_rd, m_addr;
        logic [3:0]  m_st;

        for (int k = 0; k < 4; k++) begin
            mem[k] = 32'h0; gold[k] = 32'h0;
        end
        rid = 4'd1; bid = 4'd1; rresp = 2'b00; bresp = 2'b00; rlast = 1'b1;
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0; rdata = 0;
        data_wr = 0; data_size = 2'd2; data_addr = 32'h0; data_wdata = 32'h0;

        // Reset: a pending request must not be accepted while in reset.
        rst = 1; data_req = 1;
        repeat (2) next_cycle();
        #1;
        check("rst_addr_ok", data_addr_ok, 0);
        check("rst_valids", {arvalid, awvalid, wvalid, rready, bready, data_data_ok}, 0);
        check("rst_latched", {araddr[27:0], wstrb}, 0);
        rst = 0; data_req = 0;
        #1; check("rst_idle_no_req", data_addr_ok, 0);
        next_cycle();

        // 1. Word read with arready one cycle late.
        data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h1FC0_0004;
        #1; check("rd_addr_ok", data_addr_ok, 1);
        next_cycle();
        data_req = 0;
        #1;
        check("rd_arvalid", arvalid, 1);
        check("rd_araddr", araddr, 32'h1FC0_0004);
        check("rd_arsize", arsize, 3'd2);
        check("rd_ar_const", {arid, arlen, arburst, arlock, arcache, arprot}, {4'd1, 4'd0, 2'b01, 9'd0});
        check("rd_busy_refuse", data_addr_ok, 0);
        next_cycle();
        arready = 1;
        #1; check("rd_arvalid_hold", {arvalid, araddr}, {1'b1, 32'h1FC0_0004});
        next_cycle();
        arready = 0;
        #1;
        check("rd_rready", {rready, arvalid}, 2'b10);
        check("rd_no_early_ok", {data_data_ok, data_rdata}, 0);
        next_cycle();
        rvalid = 1; rdata = 32'hDEAD_BEEF;
        #1;
        check("rd_data_ok", data_data_ok, 1);
        check("rd_rdata", data_rdata, 32'hDEAD_BEEF);
        next_cycle();
        rvalid = 0; rdata = 32'h0;
        #1; check("rd_single_ok", {data_data_ok, rready}, 0);

        // 2. Byte write at offset 3.
        data_req = 1; data_wr = 1; data_size = 2'd0;
        data_addr = 32'h8000_0003; data_wdata = 32'hAB00_0000;
        #1; check("bw_addr_ok", data_addr_ok, 1);
        next_cycle();
        data_req = 0; awready = 1; wready = 1;
        #1;
        check("bw_valids", {awvalid, wvalid}, 2'b11);
        check("bw_awaddr", awaddr, 32'h8000_0003);
        check("bw_awsize", awsize, 3'd0);
        check("bw_wstrb", wstrb, 4'b1000);
        check("bw_wdata", wdata, 32'hAB00_0000);
        check("bw_const", {awid, wid, awlen, awburst, wlast}, {4'd1, 4'd1, 4'd0, 2'b01, 1'b1});
        next_cycle();
        awready = 0; wready = 0;
        #1;
        check("bw_resp_state", {awvalid, wvalid, bready, data_data_ok}, 4'b0010);
        next_cycle();
        bvalid = 1;
        #1; check("bw_data_ok", {data_data_ok, data_rdata}, {1'b1, 32'h0});
        next_cycle();
        bvalid = 0;
        #1; check("bw_single_ok", data_data_ok, 0);

        // 3. Half writes with every AW/W ordering.
        half_write(3, 0, "hw_w_first");
        half_write(0, 3, "hw_aw_first");
        half_write(0, 0, "hw_same");

        // 4. Request held during a pending read is refused until IDLE.
        data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h0000_0100;
        #1; check("bb_first_ok", data_addr_ok, 1);
        next_cycle();
        data_addr = 32'h0000_0200; arready = 1;
        #1; check("bb_refuse_ar", data_addr_ok, 0);
        next_cycle();
        arready = 0;
        #1; check("bb_refuse_r", data_addr_ok, 0);
        next_cycle();
        rvalid = 1; rdata = 32'h1234_5678;
        #1; check("bb_ok_no_accept", {data_data_ok, data_addr_ok, data_rdata}, {2'b10, 32'h1234_5678});
        next_cycle();
        rvalid = 0; rdata = 0;
        #1; check("bb_second_accept", {data_addr_ok, data_data_ok}, 2'b10);
        next_cycle();
        data_req = 0; arready = 1;
        #1; check("bb_second_araddr", {arvalid, araddr}, {1'b1, 32'h0000_0200});
        next_cycle();
        arready = 0; rvalid = 1; rdata = 32'hCAFE_F00D;
        #1; check("bb_second_data", {data_data_ok, data_rdata}, {1'b1, 32'hCAFE_F00D});
        next_cycle();
        rvalid = 0; rdata = 0;

        // 5. Reset while waiting for read data.
        data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h0000_0040;
        #1; check("rr_addr_ok", data_addr_ok, 1);
        next_cycle();
        data_req = 0; arready = 1;
        #1; check("rr_arvalid", arvalid, 1);
        next_cycle();
        arready = 0; rst = 1;
        #1; check("rr_no_ok_in_rst", data_data_ok, 0);
        next_cycle();
        rst = 0; data_req = 1; data_addr = 32'h0000_0044;
        #1;
        check("rr_valids_low", {arvalid, awvalid, wvalid, rready, bready, data_data_ok}, 0);
        check("rr_addr_cleared", araddr, 32'h0);
        check("rr_idle_accept", data_addr_ok, 1);
        next_cycle();
        data_req = 0; arready = 1;
        #1; check("rr_fresh_araddr", araddr, 32'h0000_0044);
        next_cycle();
        arready = 0; rvalid = 1; rdata = 32'h0BAD_CAFE;
        #1; check("rr_fresh_data", {data_data_ok, data_rdata}, {1'b1, 32'h0BAD_CAFE});
        next_cycle();
        rvalid = 0; rdata = 0;

        // 6. Mixed traffic against the memory model, including size 3.
        for (int i = 0; i < 32; i++) begin
            m_wr  = (i < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            m_sz  = 2'($urandom_range(0, 3));
            m_idx = 2'($urandom_range(0, 3));
            m_off = (m_sz == 2'd0) ? 2'($urandom_range(0, 3)) :
                    (m_sz == 2'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'd0;
            m_wd  = $urandom;
            m_addr = 32'h8000_0100 + {28'd0, m_idx, 2'b00} + {30'd0, m_off};
            axi_txn(m_wr, m_sz, m_addr, m_wd, m_rd);
            if (m_wr) begin
                m_st = exp_strb(m_sz, m_off);
                for (int b = 0; b < 4; b++)
                    if (m_st[b]) gold[m_idx][8*b +: 8] = m_wd[8*b +: 8];
            end else begin
                check("mix_rdata", m_rd, gold[m_idx]);
            end
        end
        for (int k = 0; k < 4; k++) check("mix_mem", mem[k], gold[k]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
